// File: rtl/uart_cmd_asm_if.sv
// Bundle of signals between the UART receiver, the command assembler and the
// command consumer.
//   master : environment side (drives received bytes and the consumer ack)
//   slave  : the assembler itself
interface uart_cmd_asm_if;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frame_err;

    modport master (
        output rx_data, rx_rdy, clr_cmd_rdy,
        input  clr_rx_rdy, cmd, data, cmd_rdy, frame_err
    );

    modport slave (
        input  rx_data, rx_rdy, clr_cmd_rdy,
        output clr_rx_rdy, cmd, data, cmd_rdy, frame_err
    );
endinterface

// File: rtl/uart_cmd_asm.sv
// UART command frame assembler.
// Collects byte0 -> cmd, byte1 -> data[15:8], byte2 -> data[7:0] from a UART
// receiver, presents the frame until the consumer acknowledges it, and drops
// partial frames after TIMEOUT_CLKS idle cycles between bytes.
// Optional feature macro: UART_CMD_CHKSUM_EN adds a 4th byte that must equal
// byte0^byte1^byte2; a mismatch discards the frame with a frame_err pulse.
module uart_cmd_asm #(
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cmd_asm_if.slave  bus
);

    // Last counter value that still allows a byte; reaching it idle ends the frame.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B1   = 3'd1,
        ST_B2   = 3'd2,
`ifdef UART_CMD_CHKSUM_EN
        ST_CHK  = 3'd3,
`endif
        ST_FULL = 3'd4
    } state_t;

`ifdef UART_CMD_CHKSUM_EN
    // Frame check byte: XOR of the three payload bytes.
    function automatic logic [7:0] frame_xor(input logic [7:0] b0,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q;
    logic        frame_err_q, frame_err_d;
    logic        accept_s;
    logic        timeout_s;

    // A byte is taken whenever one is offered and no completed frame is waiting.
    assign accept_s  = bus.rx_rdy && (state_q != ST_FULL);
    assign timeout_s = (cnt_q == TO_LAST);

    // Next-state, capture and counter logic for the frame assembly FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (accept_s) begin
                    cmd_d   = bus.rx_data;
                    state_d = ST_B1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_B1: begin
                if (accept_s) begin
                    data_d[15:8] = bus.rx_data;
                    cnt_d        = 16'd0;
                    state_d      = ST_B2;
                end else if (timeout_s) begin
                    cnt_d       = 16'd0;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_B2: begin
                if (accept_s) begin
                    data_d[7:0] = bus.rx_data;
                    cnt_d       = 16'd0;
`ifdef UART_CMD_CHKSUM_EN
                    state_d     = ST_CHK;
`else
                    state_d     = ST_FULL;
`endif
                end else if (timeout_s) begin
                    cnt_d       = 16'd0;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    cnt_d = 16'd0;
                    if (bus.rx_data == frame_xor(cmd_q, data_q[15:8], data_q[7:0])) begin
                        state_d = ST_FULL;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (timeout_s) begin
                    cnt_d       = 16'd0;
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            ST_FULL: begin
                // Frame is frozen here; pending bytes wait upstream.
                cnt_d = 16'd0;
                if (bus.clr_cmd_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            cmd_q       <= 8'h00;
            data_q      <= 16'h0000;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= (state_d == ST_FULL);
            frame_err_q <= frame_err_d;
        end
    end

    // The receiver clear is combinational so the flag drops at the capturing
    // edge; it is gated by rst_n so nothing is acknowledged while in reset.
    assign bus.clr_rx_rdy = accept_s && rst_n;
    assign bus.cmd        = cmd_q;
    assign bus.data       = data_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_asm.sv
// Self-checking bench for uart_cmd_asm: a queue-based frame model checked on
// every falling edge, plus hand-computed literal expectations per scenario.
module tb_uart_cmd_asm;

    localparam int TO = 40;
`ifdef UART_CMD_CHKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_cmd_asm_if ifc ();

    uart_cmd_asm #(.TIMEOUT_CLKS(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Reference model: bytes collected so far, idle edges since last byte,
    // and the outputs expected in the current cycle.
    logic [7:0]  m_frame[$];
    int          m_quiet;
    bit          m_full;
    bit          m_err;
    logic [7:0]  m_cmd;
    logic [15:0] m_data;

    int errors;
    int checks;
    int clr_count;
    int fe_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model, then advance the model over the next edge.
    task automatic model_check_step();
        bit ok;
        if (!rst_n) begin
            m_frame.delete();
            m_quiet = 0;
            m_full  = 1'b0;
            m_err   = 1'b0;
        end
        chk("cmd_rdy", ifc.cmd_rdy, m_full);
        chk("frame_err", ifc.frame_err, m_err);
        chk("clr_rx_rdy", ifc.clr_rx_rdy, rst_n && ifc.rx_rdy && !m_full);
        if (m_full) begin
            chk("cmd", ifc.cmd, m_cmd);
            chk("data", ifc.data, m_data);
        end
        if (rst_n) begin
            m_err = 1'b0;
            if (m_full) begin
                if (ifc.clr_cmd_rdy) m_full = 1'b0;
            end else if (ifc.rx_rdy) begin
                m_frame.push_back(ifc.rx_data);
                m_quiet = 0;
                if (m_frame.size() == FLEN) begin
                    ok = 1'b1;
`ifdef UART_CMD_CHKSUM_EN
                    ok = (m_frame[3] == (m_frame[0] ^ m_frame[1] ^ m_frame[2]));
`endif
                    if (ok) begin
                        m_cmd  = m_frame[0];
                        m_data = {m_frame[1], m_frame[2]};
                        m_full = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_frame.delete();
                end
            end else if (m_frame.size() != 0) begin
                m_quiet++;
                if (m_quiet >= TO) begin
                    m_err = 1'b1;
                    m_frame.delete();
                    m_quiet = 0;
                end
            end
        end
    endtask

    // One clock cycle: check at the falling edge, then act as the UART
    // receiver whose ready flag is cleared by the DUT at the rising edge.
    task automatic tick();
        logic sclr;
        @(negedge clk);
        model_check_step();
        sclr = ifc.clr_rx_rdy;
        if (sclr) clr_count++;
        if (ifc.frame_err) fe_count++;
        @(posedge clk);
        #1;
        if (sclr) ifc.rx_rdy = 1'b0;
    endtask

    task automatic present(input logic [7:0] b);
        ifc.rx_data = b;
        ifc.rx_rdy  = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 200 && ifc.rx_rdy; i++) tick();
        chk("byte_accepted", ifc.rx_rdy, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        present(b);
        wait_accept();
    endtask

    // Called right after the final byte's accepting edge.
    task automatic check_frame(input logic [7:0] c, input logic [15:0] d);
        chk("cmd_rdy_latency", ifc.cmd_rdy, 1'b1);
        chk("frame_cmd", ifc.cmd, c);
        chk("frame_data", ifc.data, d);
    endtask

    task automatic release_cmd();
        ifc.clr_cmd_rdy = 1'b1;
        tick();
        ifc.clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_cleared", ifc.cmd_rdy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        errors          = 0;
        checks          = 0;
        clr_count       = 0;
        fe_count        = 0;
        m_quiet         = 0;
        m_full          = 1'b0;
        m_err           = 1'b0;
        m_cmd           = 8'h00;
        m_data          = 16'h0000;
        rst_n           = 1'b0;
        ifc.rx_data     = 8'h00;
        ifc.rx_rdy      = 1'b0;
        ifc.clr_cmd_rdy = 1'b0;

        // Reset values.
        repeat (3) tick();
        chk("rst_cmd", ifc.cmd, 8'h00);
        chk("rst_data", ifc.data, 16'h0000);
        chk("rst_cmd_rdy", ifc.cmd_rdy, 1'b0);
        chk("rst_frame_err", ifc.frame_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic frame A5 12 34 (83).
        clr_count = 0;
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'h83);
`endif
        check_frame(8'hA5, 16'h1234);
        chk("clr_pulses", clr_count, FLEN);

        // Backpressure while the frame waits for the consumer.
        present(8'h01);
        repeat (100) tick();
        chk("bp_pending", ifc.rx_rdy, 1'b1);
        chk("bp_cmd", ifc.cmd, 8'hA5);
        chk("bp_data", ifc.data, 16'h1234);
        release_cmd();
        chk("bp_not_yet", ifc.rx_rdy, 1'b1);
        wait_accept();
        send_byte(8'h02);
        send_byte(8'h03);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'h00);
`endif
        check_frame(8'h01, 16'h0203);
        release_cmd();

        // Timeout after a lone byte.
        fe_count = 0;
        send_byte(8'h10);
        repeat (TO) tick();
        chk("to_not_early", fe_count, 0);
        chk("to_err_high", ifc.frame_err, 1'b1);
        tick();
        chk("to_err_once", fe_count, 1);
        chk("to_err_low", ifc.frame_err, 1'b0);
        repeat (5) tick();
        chk("to_err_single", fe_count, 1);
        chk("to_no_cmd", ifc.cmd_rdy, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'h44);
`endif
        check_frame(8'h55, 16'h6677);
        release_cmd();

        // Byte lands on the last allowed cycle.
        fe_count = 0;
        send_byte(8'h20);
        repeat (TO - 1) tick();
        send_byte(8'h21);
        chk("edge_no_err", fe_count, 0);
        send_byte(8'h22);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'h23);
`endif
        check_frame(8'h20, 16'h2122);
        chk("edge_no_err_end", fe_count, 0);
        release_cmd();

`ifdef UART_CMD_CHKSUM_EN
        // Bad check byte.
        fe_count = 0;
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        chk("cs_err_high", ifc.frame_err, 1'b1);
        chk("cs_no_cmd", ifc.cmd_rdy, 1'b0);
        tick();
        chk("cs_err_low", ifc.frame_err, 1'b0);
        repeat (3) tick();
        chk("cs_no_cmd_later", ifc.cmd_rdy, 1'b0);
        chk("cs_err_once", fe_count, 1);
`endif

        // Reset in the middle of a frame, with a byte offered during reset.
        fe_count = 0;
        send_byte(8'hA5);
        send_byte(8'h12);
        rst_n = 1'b0;
        present(8'h34);
        #1;
        chk("mid_rst_cmd", ifc.cmd, 8'h00);
        chk("mid_rst_data", ifc.data, 16'h0000);
        chk("mid_rst_cmd_rdy", ifc.cmd_rdy, 1'b0);
        chk("mid_rst_frame_err", ifc.frame_err, 1'b0);
        chk("mid_rst_clr", ifc.clr_rx_rdy, 1'b0);
        repeat (2) tick();
        ifc.rx_rdy = 1'b0;
        rst_n      = 1'b1;
        send_byte(8'hC3);
        send_byte(8'h5A);
        send_byte(8'h0F);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'h96);
`endif
        check_frame(8'hC3, 16'h5A0F);
        chk("rst_no_err", fe_count, 0);
        release_cmd();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_asm.md
UART_CMD_ASM -- requirements
Module: uart_cmd_asm

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 2048, inter-byte timeout in clk cycles (valid 2..65535).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  received byte from UART receiver, valid while rx_rdy=1.
REQ-005 SHALL have port rx_rdy  input  1  UART receiver byte-ready flag, level, held until cleared.
REQ-006 SHALL have port clr_rx_rdy  output  1  one-cycle clear to UART receiver ready flag.
REQ-007 SHALL have port cmd  output  8  command opcode of the assembled frame.
REQ-008 SHALL have port data  output  16  command payload of the assembled frame.
REQ-009 SHALL have port cmd_rdy  output  1  assembled frame valid, level.
REQ-010 SHALL have port clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on frame discard (timeout or checksum failure).

Function
REQ-012 SHALL accept frame bytes in order: byte0 -> cmd, byte1 -> data[15:8], byte2 -> data[7:0].
REQ-013 SHALL have states IDLE, B1, B2, CHK, FULL; CHK exists only per REQ-030.
REQ-014 SHALL accept a byte in any cycle where rx_rdy=1 and state is IDLE, B1, B2 or CHK: capture rx_data at that edge, drive clr_rx_rdy=1 combinationally in the same cycle.
REQ-015 SHALL keep clr_rx_rdy=0 in FULL; a byte arriving during FULL stays pending upstream (backpressure), not dropped, not captured.
REQ-016 SHALL transition IDLE->B1 on byte0, B1->B2 on byte1, B2->FULL on byte2 (B2->CHK with REQ-030).
REQ-017 SHALL assert cmd_rdy on the cycle after the final byte is accepted; latency final-byte-edge to cmd_rdy = 1 cycle.
REQ-018 SHALL hold cmd and data stable while cmd_rdy=1; values otherwise undefined to consumer.
REQ-019 SHALL, in FULL with clr_cmd_rdy=1, deassert cmd_rdy and enter IDLE at the next edge; a pending rx_rdy is accepted no earlier than the following cycle.
REQ-020 SHALL ignore clr_cmd_rdy outside FULL.
REQ-021 SHALL run a 16-bit inter-byte counter in B1, B2, CHK: cleared on each accepted byte, incremented otherwise.
REQ-022 SHALL, when the counter reaches TIMEOUT_CLKS-1 without an accepted byte, discard the partial frame, pulse frame_err for one cycle, enter IDLE.
REQ-023 SHALL give byte acceptance priority over timeout when both occur in the same cycle.
REQ-024 SHALL hold the counter at 0 in IDLE and FULL; no timeout in those states.
REQ-025 SHALL never assert clr_rx_rdy for more than one consecutive cycle per byte.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously force state IDLE, counter 0, cmd_rdy 0, frame_err 0, clr_rx_rdy 0, cmd 8'h00, data 16'h0000.
REQ-027 SHALL discard any partial or completed frame on reset mid-operation, with no frame_err pulse.
REQ-028 SHALL resume normal operation on the first clk edge after rst_n rises.

Configuration
REQ-029 SHALL use macro UART_CMD_CHKSUM_EN to compile the checksum feature in or out.
REQ-030 SHALL, with UART_CMD_CHKSUM_EN defined, expect a 4th byte equal to byte0^byte1^byte2: match -> FULL; mismatch -> frame_err one-cycle pulse, no cmd_rdy, enter IDLE.
REQ-031 SHALL, without UART_CMD_CHKSUM_EN, use 3-byte frames, omit CHK, and assert frame_err only on timeout.

Verification
REQ-032 SHALL cover: bytes 8'hA5, 8'h12, 8'h34 (plus 8'h83 with checksum) -> cmd_rdy=1 one cycle after last byte, cmd=8'hA5, data=16'h1234, one clr_rx_rdy pulse per byte.
REQ-033 SHALL cover: frame complete, next byte 8'h01 arrives, clr_cmd_rdy held 0 for 100 cycles -> clr_rx_rdy stays 0, cmd/data unchanged; after clr_cmd_rdy pulse, 8'h01 accepted as new byte0.
REQ-034 SHALL cover: byte 8'h10 then silence of TIMEOUT_CLKS cycles -> frame_err one-cycle pulse, state IDLE, next 3/4 bytes form a correct frame.
REQ-035 SHALL cover: byte accepted on exact cycle counter hits TIMEOUT_CLKS-1 -> no frame_err, frame continues.
REQ-036 SHALL cover (UART_CMD_CHKSUM_EN): bytes 8'hA5, 8'h12, 8'h34, 8'h00 -> frame_err pulse, cmd_rdy stays 0.
REQ-037 SHALL cover: rst_n asserted after byte1 -> all outputs at reset values immediately; following full frame assembles correctly.
